dram_traffic_gen: RTL

Synthesizable, parametrised stimulus-and-check engine for `dram_ctrl`; it replaces hand-written write/read loops in bench top levels and allows on-board self-test. It drives the controller's L2 request port through a write phase and then a read-back phase, using a selectable address mode. Each read response is compared against a data pattern derived from the address, and a pass/fail status with an error count is reported. No memory shadow is required.

---
 rtl/dram_ctrl_pkg.sv | 56 +++++
 rtl/tg_addr_gen.sv | 71 +++++++
 rtl/dram_traffic_gen.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/dram_ctrl_pkg.sv
// Types and helpers shared by the DRAM traffic generator and dram_ctrl:
// address modes, generator FSM states, field widths and LFSR tap masks.
package dram_ctrl_pkg;

    typedef enum logic [1:0] {
        TG_SEQ  = 2'd0,
        TG_RAND = 2'd1,
        TG_BANK = 2'd2
    } tg_mode_e;

    typedef enum logic [2:0] {
        TG_IDLE  = 3'd0,
        TG_WRITE = 3'd1,
        TG_READ  = 3'd2,
        TG_DRAIN = 3'd3,
        TG_DONE  = 3'd4
    } tg_state_e;

    function automatic int field_width(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

    // Fibonacci feedback masks (bit k set = stage k+1 tapped), maximal length
    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            32'sd3:  return 32'h0000_0006;
            32'sd4:  return 32'h0000_000C;
            32'sd5:  return 32'h0000_0014;
            32'sd6:  return 32'h0000_0030;
            32'sd7:  return 32'h0000_0060;
            32'sd8:  return 32'h0000_00B8;
            32'sd9:  return 32'h0000_0110;
            32'sd10: return 32'h0000_0240;
            32'sd11: return 32'h0000_0500;
            32'sd12: return 32'h0000_0829;
            32'sd13: return 32'h0000_100D;
            32'sd14: return 32'h0000_2015;
            32'sd15: return 32'h0000_6000;
            32'sd16: return 32'h0000_D008;
            32'sd17: return 32'h0001_2000;
            32'sd18: return 32'h0002_0400;
            32'sd19: return 32'h0004_0023;
            32'sd20: return 32'h0009_0000;
            default: return 32'h0000_100D;
        endcase
    endfunction

    function automatic tg_mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return TG_RAND;
            2'd2:    return TG_BANK;
            default: return TG_SEQ;
        endcase
    endfunction

endpackage

// File: rtl/tg_addr_gen.sv
// Address sequencer for the traffic generator: sequential, LFSR or
// single-bank stride. Exposes both the current address and its next value.
module tg_addr_gen
    import dram_ctrl_pkg::*;
#(
    parameter int BANK_W    = 3,
    parameter int ROW_W     = 7,
    parameter int COL_W     = 3,
    parameter int LFSR_SEED = 1,
    localparam int ADDR_W   = BANK_W + ROW_W + COL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  tg_mode_e          i_mode,
    input  logic [BANK_W-1:0] i_bank_sel,
    input  logic              i_load,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_addr,
    output logic [ADDR_W-1:0] o_addr_d
);

    localparam int RC_W = ROW_W + COL_W;
    localparam logic [ADDR_W-1:0] TAP_MASK = ADDR_W'(lfsr_taps(ADDR_W));

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_start;
    logic [ADDR_W-1:0] w_step;

    // start value and successor for the active mode
    always_comb begin
        w_start = {ADDR_W{1'b0}};
        w_step  = r_addr;
        case (i_mode)
            TG_RAND: begin
                w_start = ADDR_W'(LFSR_SEED);
                w_step  = {r_addr[ADDR_W-2:0], ^(r_addr & TAP_MASK)};
            end
            TG_BANK: begin
                w_start = {i_bank_sel, {RC_W{1'b0}}};
                w_step  = {i_bank_sel, r_addr[RC_W-1:0] + RC_W'(1'b1)};
            end
            default: begin
                w_start = {ADDR_W{1'b0}};
                w_step  = r_addr + ADDR_W'(1'b1);
            end
        endcase
    end

    // load takes priority over advance
    always_comb begin
        if (i_load) begin
            o_addr_d = w_start;
        end else if (i_advance) begin
            o_addr_d = w_step;
        end else begin
            o_addr_d = r_addr;
        end
    end

    // address register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= {ADDR_W{1'b0}};
        end else begin
            r_addr <= o_addr_d;
        end
    end

    assign o_addr = r_addr;

endmodule

// File: rtl/dram_traffic_gen.sv
// Write-then-read-back traffic engine for dram_ctrl; checks every read
// response against an address-derived pattern and reports pass/fail.
module dram_traffic_gen
    import dram_ctrl_pkg::*;
#(
    parameter int                    L2_REQ_WIDTH    = 20,
    parameter int                    DATA_WIDTH      = 8,
    parameter int                    NUM_OF_BANKS    = 8,
    parameter int                    NUM_OF_ROWS     = 128,
    parameter int                    NUM_OF_COLS     = 8,
    parameter int                    MAX_REQS        = 1024,
    parameter int                    MAX_OUTSTANDING = 4,
    parameter logic [DATA_WIDTH-1:0] PATTERN_XOR     = 8'hA5,
    parameter int                    LFSR_SEED       = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [1:0]                         mode,
    input  logic [$clog2(MAX_REQS+1)-1:0]      num_reqs,
    input  logic [$clog2(NUM_OF_BANKS)-1:0]    bank_sel,
    output logic                               l2_req_valid,
    input  logic                               l2_req_ready,
    output logic                               l2_rw_req,
    output logic [L2_REQ_WIDTH-1:0]            l2_req_instr,
    output logic [DATA_WIDTH-1:0]              l2_req_data,
    input  logic                               l2_rsp_valid,
    input  logic [DATA_WIDTH-1:0]              l2_rsp_data,
    output logic                               busy,
    output logic                               done,
    output logic                               pass,
    output logic [15:0]                        err_count,
    output logic [L2_REQ_WIDTH-1:0]            first_err_addr
);

    localparam int BANK_W = field_width(NUM_OF_BANKS);
    localparam int ROW_W  = field_width(NUM_OF_ROWS);
    localparam int COL_W  = field_width(NUM_OF_COLS);
    localparam int ADDR_W = BANK_W + ROW_W + COL_W;
    localparam int NREQ_W = $clog2(MAX_REQS + 1);
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    tg_state_e               r_state, w_state_nxt;
    tg_mode_e                r_mode, w_mode_in, w_gen_mode;
    logic [BANK_W-1:0]       r_bank_sel, w_gen_bank;
    logic [NREQ_W-1:0]       r_num, r_cnt;
    logic                    r_valid, r_rw;
    logic [L2_REQ_WIDTH-1:0] r_instr, r_first, w_first_nxt;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [OUT_W-1:0]        r_out, w_out_nxt;
    logic [15:0]             r_err, w_err_nxt;
    logic                    r_busy, r_done, r_pass;

    logic                    w_start_ok, w_hs, w_last, w_rd_hs, w_rsp_ok;
    logic                    w_mis, w_spur;
    logic                    w_req_load, w_req_adv, w_rsp_load;
    logic [ADDR_W-1:0]       w_req_addr, w_req_addr_d, w_rsp_addr, w_rsp_addr_d;
    logic [L2_REQ_WIDTH-1:0] w_req_instr_d;
    logic [DATA_WIDTH-1:0]   w_wr_data_d, w_exp;

    assign w_start_ok    = start && ((r_state == TG_IDLE) || (r_state == TG_DONE));
    assign w_mode_in     = decode_mode(mode);
    assign w_gen_mode    = w_start_ok ? w_mode_in : r_mode;
    assign w_gen_bank    = w_start_ok ? bank_sel : r_bank_sel;
    assign w_hs          = r_valid && l2_req_ready;
    assign w_last        = (r_cnt == (r_num - NREQ_W'(1'b1)));
    assign w_rd_hs       = w_hs && (r_state == TG_READ);
    assign w_rsp_ok      = l2_rsp_valid && (r_out != {OUT_W{1'b0}}) &&
                           ((r_state == TG_READ) || (r_state == TG_DRAIN));
    assign w_out_nxt     = r_out + OUT_W'(w_rd_hs) - OUT_W'(w_rsp_ok);
    assign w_req_instr_d = L2_REQ_WIDTH'(w_req_addr_d);
    assign w_wr_data_d   = w_req_addr_d[DATA_WIDTH-1:0] ^ PATTERN_XOR;
    assign w_exp         = w_rsp_addr[DATA_WIDTH-1:0] ^ PATTERN_XOR;
    assign w_mis         = w_rsp_ok && (l2_rsp_data != w_exp);
    assign w_spur        = l2_rsp_valid && !w_rsp_ok;

    tg_addr_gen #(
        .BANK_W(BANK_W), .ROW_W(ROW_W), .COL_W(COL_W), .LFSR_SEED(LFSR_SEED)
    ) u_req_gen (
        .clk(clk), .rst(rst), .i_mode(w_gen_mode), .i_bank_sel(w_gen_bank),
        .i_load(w_req_load), .i_advance(w_req_adv),
        .o_addr(w_req_addr), .o_addr_d(w_req_addr_d)
    );

    tg_addr_gen #(
        .BANK_W(BANK_W), .ROW_W(ROW_W), .COL_W(COL_W), .LFSR_SEED(LFSR_SEED)
    ) u_rsp_gen (
        .clk(clk), .rst(rst), .i_mode(w_gen_mode), .i_bank_sel(w_gen_bank),
        .i_load(w_rsp_load), .i_advance(w_rsp_ok),
        .o_addr(w_rsp_addr), .o_addr_d(w_rsp_addr_d)
    );

    // next-state and address-generator control
    always_comb begin
        w_state_nxt = r_state;
        w_req_load  = 1'b0;
        w_req_adv   = 1'b0;
        w_rsp_load  = 1'b0;
        case (r_state)
            TG_IDLE, TG_DONE: begin
                if (w_start_ok) begin
                    w_state_nxt = (num_reqs == {NREQ_W{1'b0}}) ? TG_DONE : TG_WRITE;
                    w_req_load  = 1'b1;
                    w_rsp_load  = 1'b1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            TG_WRITE: begin
                if (w_hs && w_last) begin
                    w_state_nxt = TG_READ;
                    w_req_load  = 1'b1;
                    w_rsp_load  = 1'b1;
                end else begin
                    w_req_adv   = w_hs;
                end
            end
            TG_READ: begin
                if (w_hs && w_last) begin
                    w_state_nxt = TG_DRAIN;
                end else begin
                    w_req_adv   = w_hs;
                end
            end
            TG_DRAIN: begin
                if (r_out == {OUT_W{1'b0}}) begin
                    w_state_nxt = TG_DONE;
                end else begin
                    w_state_nxt = TG_DRAIN;
                end
            end
            default: w_state_nxt = TG_IDLE;
        endcase
    end

    // error counter and first-failure capture
    always_comb begin
        w_err_nxt   = r_err;
        w_first_nxt = r_first;
        if (w_start_ok) begin
            w_err_nxt   = 16'h0000;
            w_first_nxt = {L2_REQ_WIDTH{1'b0}};
        end else if ((w_mis || w_spur) && (r_err != 16'hFFFF)) begin
            w_err_nxt = r_err + 16'h0001;
            if (w_mis && (r_err == 16'h0000)) begin
                w_first_nxt = L2_REQ_WIDTH'(w_rsp_addr);
            end else begin
                w_first_nxt = r_first;
            end
        end else begin
            w_err_nxt   = r_err;
            w_first_nxt = r_first;
        end
    end

    // FSM, request register and outstanding-read tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= TG_IDLE;
            r_mode     <= TG_SEQ;
            r_bank_sel <= {BANK_W{1'b0}};
            r_num      <= {NREQ_W{1'b0}};
            r_cnt      <= {NREQ_W{1'b0}};
            r_valid    <= 1'b0;
            r_rw       <= 1'b0;
            r_instr    <= {L2_REQ_WIDTH{1'b0}};
            r_data     <= {DATA_WIDTH{1'b0}};
            r_out      <= {OUT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            if (w_start_ok) begin
                r_mode     <= w_mode_in;
                r_bank_sel <= bank_sel;
                r_num      <= num_reqs;
                r_cnt      <= {NREQ_W{1'b0}};
                r_valid    <= (num_reqs != {NREQ_W{1'b0}});
                r_rw       <= (num_reqs != {NREQ_W{1'b0}});
                r_instr    <= (num_reqs != {NREQ_W{1'b0}}) ? w_req_instr_d : {L2_REQ_WIDTH{1'b0}};
                r_data     <= (num_reqs != {NREQ_W{1'b0}}) ? w_wr_data_d : {DATA_WIDTH{1'b0}};
            end else if ((r_state == TG_WRITE) && w_hs) begin
                // last write hands straight over to the first read
                r_instr <= w_req_instr_d;
                r_cnt   <= w_last ? {NREQ_W{1'b0}} : (r_cnt + NREQ_W'(1'b1));
                r_rw    <= !w_last;
                r_data  <= w_last ? {DATA_WIDTH{1'b0}} : w_wr_data_d;
            end else if (r_state == TG_READ) begin
                if (w_hs) begin
                    r_cnt   <= r_cnt + NREQ_W'(1'b1);
                    r_instr <= w_req_instr_d;
                    r_valid <= !w_last && (w_out_nxt != OUT_MAX);
                end else if (!r_valid) begin
                    r_valid <= (w_out_nxt != OUT_MAX);
                end
            end
        end
    end

    // status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err   <= 16'h0000;
            r_first <= {L2_REQ_WIDTH{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_err   <= w_err_nxt;
            r_first <= w_first_nxt;
            r_busy  <= (w_state_nxt == TG_WRITE) || (w_state_nxt == TG_READ) ||
                       (w_state_nxt == TG_DRAIN);
            r_done  <= (w_state_nxt == TG_DONE);
            r_pass  <= (w_state_nxt == TG_DONE) && (w_err_nxt == 16'h0000);
        end
    end

    assign l2_req_valid   = r_valid;
    assign l2_rw_req      = r_rw;
    assign l2_req_instr   = r_instr;
    assign l2_req_data    = r_data;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err;
    assign first_err_addr = r_first;

endmodule
